addr_gen: RTL
=============

# addr_gen

Upstream address source for `adu`. It assembles a 16-bit address from two bytes on the 8-bit data bus, low byte first, using a valid/ready handshake, or steps the current address up or down by one. It presents the result on `a[15:0]` with a one-cycle `we` strobe that loads it into `adu`. It also carries the single-step increment/decrement that the program-counter and pointer paths need.

## Interface
- `RESET_VEC`, default 16'h0000: value of `a` after reset.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset: synchronous, active-high; clock `clk`.
- `d`  in  8  byte from the data bus, sampled on an accepted handshake.
- `d_valid`  in  1  `d` holds a valid byte this cycle.
- `d_ready`  out  1  block accepts a byte this cycle.
- `ld`  in  1  start a two-byte load (low then high).
- `inc`  in  1  step `a` by +1.
- `dec`  in  1  step `a` by -1.
- `a`  out  16  current address; drives `adu.a`.
- `we`  out  1  one-cycle strobe: `a` changed this cycle; drives `adu.we`.
- `busy`  out  1  load sequence in progress (state != IDLE).
- `wrap`  out  1  one-cycle strobe: the last step wrapped past FFFF or 0000.

## Operation
- States: IDLE, GET_LO, GET_HI, COMMIT. Registers: `a`, `lo_stg[7:0]`, `hi_stg[7:0]`, `we`, `wrap`.
- Reset values: state=IDLE, `a`=RESET_VEC, `lo_stg`=`hi_stg`=0, `we`=0, `wrap`=0.
- Reset outputs: `d_ready`=0, `busy`=0.
- `rst` overrides all other inputs in every state. A load aborted by reset discards its staged bytes and raises no `we`.
- IDLE:
  - `ld`=1: go to GET_LO. `ld` has priority over `inc`/`dec`.
  - `inc`=1 and `dec`=0: `a`<=`a`+1 mod 2^16, `we`<=1. `wrap`<=1 iff the old `a`=16'hFFFF.
  - `dec`=1 and `inc`=0: `a`<=`a`-1 mod 2^16, `we`<=1. `wrap`<=1 iff the old `a`=16'h0000.
  - `inc`=`dec`=1: no-op; `a` unchanged, `we`=0.
- GET_LO: `d_ready`=1. On `d_valid`: `lo_stg`<=`d`, go to GET_HI. Otherwise wait indefinitely.
- GET_HI: `d_ready`=1. On `d_valid`: `hi_stg`<=`d`, go to COMMIT.
- COMMIT: `d_ready`=0. `a`<={`hi_stg`,`lo_stg`}, `we`<=1, `wrap`<=0, go to IDLE.
- `ld`, `inc` and `dec` are ignored outside IDLE; there is no queueing.
- `d_valid` is ignored while `d_ready`=0.
- `we` and `wrap` are 0 on every cycle not listed above.
- `a` is stable except on the single edge that sets `we`.
- `d_ready`=1 exactly in GET_LO and GET_HI. `busy`=1 in every state except IDLE.
- `d_ready` and `busy` are decoded from the registered state only, with no combinational path from any input.

## Timing
- Edge numbering: cycle N ends at edge N.
- Load latency:
  - `ld` sampled at edge 0 → GET_LO in cycle 1.
  - With `d_valid` held high: low byte taken at edge 1, high byte at edge 2, COMMIT in cycle 3.
  - New `a` and `we`=1 in cycle 4. The minimum from `ld` to `we` is 4 cycles.
- Each cycle `d_valid` is low in GET_LO or GET_HI adds one cycle of latency.
- Step latency: `inc`/`dec` sampled at edge 0 → new `a`, `we`=1 (and `wrap` if applicable) in cycle 1.
- Back-to-back steps are supported: `inc` held for k cycles gives k consecutive `we` pulses and `a` advanced by k.
- A new `ld` is accepted in the same cycle `we` from COMMIT is high, because the block is in IDLE then.
- `adu` captures `a` at the edge ending the `we`=1 cycle. `a` is held constant through that edge.

## Test plan
- Reset: assert `rst` 2 cycles with RESET_VEC=16'h0000 → `a`=0000, `we`=0, `wrap`=0, `d_ready`=0, `busy`=0.
- Load: pulse `ld`, then supply `d`=8'h34 then 8'h12 with `d_valid` held high → `a`=16'h1234 and `we`=1 exactly in cycle 4; `busy` high in cycles 1-3.
- Stalled handshake: `d_valid` low for 3 cycles in GET_LO and 2 cycles in GET_HI; ignore garbage on `d` while `d_valid`=0 and assert that `inc` pulses and a second `ld` during these cycles have no effect → `a`=16'hBEEF (bytes EF, BE) after 9 cycles, single `we`.
- Wrap: load 16'hFFFF, pulse `inc` → `a`=0000, `we`=1, `wrap`=1 for one cycle; pulse `dec` → `a`=FFFF, `wrap`=1 for one cycle.
- Conflicts: in IDLE with `a`=16'h0100, assert `inc`+`dec` together → no change, `we`=0; assert `ld`+`inc` together → load starts and `a` stays 0100 until COMMIT.
- Reset mid-load: `ld`, accept low byte 8'hAA, assert `rst` in GET_HI → next cycle state=IDLE, `a`=RESET_VEC, no `we`; a following load of 8'h01, 8'h00 gives `a`=16'h0001.

Source files
------------

// File: rtl/addr_gen.sv
// Upstream address source for adu: assembles a 16-bit address from two bus bytes
// (low first) or steps the current address by +/-1, strobing we when a changes.
module addr_gen #(
    parameter logic [15:0] RESET_VEC = 16'h0000,
    localparam int unsigned AW = 16,
    localparam int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] d,
    input  logic          d_valid,
    output logic          d_ready,
    input  logic          ld,
    input  logic          inc,
    input  logic          dec,
    output logic [AW-1:0] a,
    output logic          we,
    output logic          busy,
    output logic          wrap
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GET_LO = 2'd1,
        GET_HI = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [DW-1:0]   lo_stg;
    logic [DW-1:0]   hi_stg;
    logic            step_up;
    logic            step_dn;
    logic            take_lo;
    logic            take_hi;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; ld wins over inc/dec in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ld)      state_nxt = GET_LO;
            GET_LO:  if (d_valid) state_nxt = GET_HI;
            GET_HI:  if (d_valid) state_nxt = COMMIT;
            COMMIT:               state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    // Outputs and datapath enables, decoded from registered state plus step inputs
    always_comb begin
        d_ready = 1'b0;
        busy    = 1'b0;
        step_up = 1'b0;
        step_dn = 1'b0;
        take_lo = 1'b0;
        take_hi = 1'b0;
        case (state)
            IDLE: begin
                step_up = !ld && inc && !dec;
                step_dn = !ld && dec && !inc;
            end
            GET_LO: begin
                d_ready = 1'b1;
                busy    = 1'b1;
                take_lo = d_valid;
            end
            GET_HI: begin
                d_ready = 1'b1;
                busy    = 1'b1;
                take_hi = d_valid;
            end
            COMMIT: begin
                busy = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // Address, staging bytes and strobes; we/wrap default low every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            a      <= RESET_VEC;
            lo_stg <= '0;
            hi_stg <= '0;
            we     <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            we   <= 1'b0;
            wrap <= 1'b0;
            if (step_up) begin
                a    <= a + AW'(1);
                we   <= 1'b1;
                wrap <= (a == '1);
            end else if (step_dn) begin
                a    <= a - AW'(1);
                we   <= 1'b1;
                wrap <= (a == '0);
            end else if (state == COMMIT) begin
                a  <= {hi_stg, lo_stg};
                we <= 1'b1;
            end
            if (take_lo) lo_stg <= d;
            if (take_hi) hi_stg <= d;
        end
    end

endmodule
